// File: rtl/calculadora_serial.sv
// Bit-serial calculator: add, subtract, AND, OR on two unsigned WIDTH-bit
// operands, one result bit per clock, with valid/ready handshakes on both
// the request and the result side.
module calculadora_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C_out,
   output logic             carry
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [1:0]       op_reg;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] res_sh;
   logic             scarry;

   logic             a_bit;
   logic             b_bit;
   logic             sum_bit;
   logic             cout;
   logic             res_bit;
   logic             last_bit;
   logic [WIDTH-1:0] res_next;

   // Result bit for the current LSB position; sub inverts B so that the
   // full adder, seeded with carry 1, computes A + ~B + 1.
   always_comb begin
      a_bit    = a_sh[0];
      b_bit    = (op_reg == OP_SUB) ? ~b_sh[0] : b_sh[0];
      sum_bit  = a_bit ^ b_bit ^ scarry;
      cout     = (a_bit & b_bit) | (a_bit & scarry) | (b_bit & scarry);
      res_bit  = sum_bit;
      if (op_reg == OP_AND) begin
         res_bit = a_sh[0] & b_sh[0];
      end else if (op_reg[1]) begin
         res_bit = a_sh[0] | b_sh[0];
      end
      last_bit = (cnt == CW'(WIDTH - 1));
      res_next = {res_bit, res_sh[WIDTH-1:1]};
   end

   // Handshake FSM with the serial datapath; C_out/carry only change when a
   // result completes, so they stay frozen through DONE and the next CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         op_reg <= '0;
         cnt    <= '0;
         res_sh <= '0;
         scarry <= 1'b0;
         C_out  <= '0;
         carry  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  op_reg <= op_sel;
                  cnt    <= '0;
                  res_sh <= '0;
                  scarry <= (op_sel == OP_SUB);
                  state  <= CALC;
               end
            end
            CALC: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               cnt    <= cnt + CW'(1);
               if (!op_reg[1]) begin
                  scarry <= cout;
               end
               if (last_bit) begin
                  state <= DONE;
                  C_out <= res_next;
                  if (op_reg == OP_ADD) begin
                     carry <= cout;
                  end else if (op_reg == OP_SUB) begin
                     carry <= ~cout;
                  end else begin
                     carry <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_calculadora_serial.sv
// Self-checking bench for calculadora_serial: a cycle-level behavioural
// model checked every negedge, directed literal cases, and random traffic.
module tb_calculadora_serial;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [1:0]   op_sel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] C_out;
   logic         carry;

   int n_vec = 0;
   int n_err = 0;

   calculadora_serial #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .A(A),
      .B(B),
      .op_sel(op_sel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .C_out(C_out),
      .carry(carry)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic report_timeout(input string name);
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
   endtask

   // Reference arithmetic straight from the operation definitions.
   task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op,
                           output logic [W-1:0] c, output logic cy);
      int sum;
      case (op)
         2'b00: begin
            sum = int'(a) + int'(b);
            c   = W'(sum);
            cy  = (sum >= (1 << W));
         end
         2'b01: begin
            sum = int'(a) - int'(b);
            c   = W'(sum);
            cy  = (a < b);
         end
         2'b10: begin
            c  = a & b;
            cy = 1'b0;
         end
         default: begin
            c  = a | b;
            cy = 1'b0;
         end
      endcase
   endtask

   // Behavioural model: 'phase' counts cycles since acceptance
   // (0 = waiting for a request, 1..W = computing, W+1 = result offered).
   int           phase = 0;
   logic [W-1:0] exp_c = '0;
   logic         exp_cy = 1'b0;
   logic [W-1:0] pend_c;
   logic         pend_cy;

   // Compare DUT outputs with the model each cycle, then advance the model
   // with the inputs that the coming rising edge will see.
   always @(negedge clk) begin
      if (!rst_n) begin
         check_output("rst_in_ready", int'(in_ready), 1);
         check_output("rst_out_valid", int'(out_valid), 0);
         check_output("rst_C_out", int'(C_out), 0);
         check_output("rst_carry", int'(carry), 0);
         phase  = 0;
         exp_c  = '0;
         exp_cy = 1'b0;
      end else begin
         check_output("in_ready", int'(in_ready), int'(phase == 0));
         check_output("out_valid", int'(out_valid), int'(phase == W + 1));
         check_output("C_out", int'(C_out), int'(exp_c));
         check_output("carry", int'(carry), int'(exp_cy));
         if (phase == 0) begin
            if (in_valid) begin
               model_op(A, B, op_sel, pend_c, pend_cy);
               phase = 1;
            end
         end else if (phase < W) begin
            phase = phase + 1;
         end else if (phase == W) begin
            phase  = W + 1;
            exp_c  = pend_c;
            exp_cy = pend_cy;
         end else if (out_ready) begin
            phase = 0;
         end
      end
   end

   // One directed request: checks latency and hand-computed result values,
   // optionally holds the result while the request inputs toggle.
   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic [W-1:0] ec,
                                 input logic ecy, input int hold);
      int  cycles;
      bit  seen;
      logic [W-1:0] held_c;
      logic         held_cy;
      @(posedge clk);
      #1;
      A = a; B = b; op_sel = op; in_valid = 1'b1; out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         report_timeout("accept");
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = W'($urandom); B = W'($urandom); op_sel = 2'($urandom);
      seen = 0;
      cycles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cycles++;
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         report_timeout("result");
         return;
      end
      check_output("latency", cycles, W + 1);
      check_output("lit_C_out", int'(C_out), int'(ec));
      check_output("lit_carry", int'(carry), int'(ecy));
      held_c  = C_out;
      held_cy = carry;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         A = W'($urandom); B = W'($urandom); in_valid = ~in_valid;
         @(negedge clk);
         check_output("hold_out_valid", int'(out_valid), 1);
         check_output("hold_in_ready", int'(in_ready), 0);
         check_output("hold_C_out", int'(C_out), int'(held_c));
         check_output("hold_carry", int'(carry), int'(held_cy));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_output("release_out_valid", int'(out_valid), 0);
      check_output("release_in_ready", int'(in_ready), 1);
   endtask

   int last_rise;
   int rises;
   int cyc;
   bit prev_ov;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; op_sel = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      apply_stimulus(4'b0011, 4'b0101, 2'b00, 4'b1000, 1'b0, 10);
      apply_stimulus(4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1, 0);
      apply_stimulus(4'b1000, 4'b0011, 2'b01, 4'b0101, 1'b0, 0);
      apply_stimulus(4'b0100, 4'b1000, 2'b01, 4'b1100, 1'b1, 0);
      apply_stimulus(4'b1100, 4'b1010, 2'b10, 4'b1000, 1'b0, 0);
      apply_stimulus(4'b0101, 4'b1001, 2'b11, 4'b1101, 1'b0, 2);

      // Abort in the second computing cycle; C_out is nonzero beforehand.
      @(posedge clk);
      #1;
      A = 4'b1111; B = 4'b1111; op_sel = 2'b00; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("abort_out_valid", int'(out_valid), 0);
      check_output("abort_C_out", int'(C_out), 0);
      check_output("abort_carry", int'(carry), 0);
      check_output("abort_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply_stimulus(4'b0010, 4'b0010, 2'b00, 4'b0100, 1'b0, 0);

      // Back-to-back traffic: result spacing must be WIDTH+2 cycles.
      @(posedge clk);
      #1;
      in_valid = 1'b1; out_ready = 1'b1;
      last_rise = -1; rises = 0; prev_ov = 1'b0;
      for (cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (out_valid && !prev_ov) begin
            if (last_rise >= 0) begin
               check_output("b2b_spacing", cyc - last_rise, W + 2);
            end
            last_rise = cyc;
            rises++;
         end
         prev_ov = out_valid;
         @(posedge clk);
         #1;
         A = W'($urandom); B = W'($urandom); op_sel = 2'($urandom);
      end
      n_vec++;
      if (rises < 8) begin
         n_err++;
         $display("[TB] FAIL b2b_count: got %0d results, expected at least 8", rises);
      end

      // Random handshake traffic checked by the model.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         A = W'($urandom); B = W'($urandom); op_sel = 2'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (W + 4) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute guard so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/calculadora_serial.md
CALCULADORA_SERIAL -- requirements
Module: calculadora_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand/result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, the request carries valid A, B and op_sel.
REQ-005 The block SHALL have port in_ready, output, 1, the block can accept a request.
REQ-006 The block SHALL have port A, input, WIDTH, first operand (unsigned).
REQ-007 The block SHALL have port B, input, WIDTH, second operand (unsigned).
REQ-008 The block SHALL have port op_sel, input, 2, operation: 00 add, 01 sub (A-B), 10 AND, 11 OR.
REQ-009 The block SHALL have port out_valid, output, 1, C_out and carry hold a completed result.
REQ-010 The block SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-011 The block SHALL have port C_out, output, WIDTH, result bits.
REQ-012 The block SHALL have port carry, output, 1: carry-out for add, borrow (A<B) for sub, 0 for AND/OR.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-015 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; A, B, op_sel are captured into internal registers, bit counter cleared, state -> CALC.
REQ-016 Before bit 0 the internal serial carry SHALL be 1 for sub and 0 otherwise; sub is computed as A + ~B + 1.
REQ-017 In CALC the block SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles, shifting each result bit into the result register.
REQ-018 Add/sub bits SHALL use a 1-bit full adder with the registered serial carry; AND/OR bits SHALL be bitwise, serial carry unused.
REQ-019 On the edge processing bit WIDTH-1 the state SHALL go to DONE; carry SHALL be set to the final serial carry (add), its inverse (sub), or 0 (AND/OR).
REQ-020 Latency: with input transfer at edge E0, out_valid SHALL first be 1 in the cycle after edge E0+WIDTH.
REQ-021 C_out and carry SHALL remain stable throughout DONE regardless of out_ready duration.
REQ-022 Output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1; state -> IDLE; C_out and carry keep their value until the next result.
REQ-023 in_valid, A, B, op_sel SHALL be ignored outside IDLE; changes after capture SHALL NOT affect the result.
REQ-024 Sustained throughput with in_valid and out_ready both held at 1 SHALL be one result every WIDTH+2 cycles.
REQ-025 Results SHALL be modulo 2^WIDTH; no overflow flag other than carry is produced.

Reset
REQ-026 While rst_n=0 the state SHALL be IDLE, C_out=0, carry=0, out_valid=0, bit counter and internal registers 0; in_ready=1.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation immediately (asynchronously) with no result presented.
REQ-028 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification (WIDTH=4)
REQ-029 A=0011,B=0101,op=00 -> 4 cycles after acceptance out_valid=1, C_out=1000, carry=0.
REQ-030 A=1111,B=0001,op=00 -> C_out=0000, carry=1; A=1000,B=0011,op=01 -> C_out=0101, carry=0.
REQ-031 A=0100,B=1000,op=01 -> C_out=1100, carry=1; A=1100,B=1010,op=10 -> C_out=1000, carry=0; A=0101,B=1001,op=11 -> C_out=1101, carry=0.
REQ-032 out_ready held 0 for 10 cycles in DONE with A/B/in_valid toggling -> out_valid, C_out, carry unchanged and in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 rst_n pulsed low during the 2nd CALC cycle -> out_valid=0, C_out=0, carry=0 immediately; new request 0010+0010 after release -> C_out=0100, carry=0.
REQ-034 Back-to-back requests with in_valid=out_ready=1 -> consecutive out_valid rising edges exactly 6 cycles apart, results in request order.
